// File: rtl/sum_bcd_pkg.sv
// ============================================================================
// Module      : sum_bcd_pkg
// Description : Shared types and constants for the sum BCD display block:
//               conversion FSM states, default sizes and the active-low
//               7-segment (gfedcba) digit patterns.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sum_bcd_pkg;

    // Default sizing: a 9-bit adder sum fits in three decimal digits
    localparam int DEFAULT_WIDTH  = 9;
    localparam int DEFAULT_DIGITS = 3;

    // Conversion sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Active-low segment patterns, bit order gfedcba
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    // Digit-to-segment lookup; non-decimal codes 10..15 show nothing
    function automatic logic [6:0] seg_of_digit(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sum_bcd_display_seg7_decode.sv
// ============================================================================
// Module      : seg7_decode
// Description : One BCD digit to active-low 7-segment pattern (gfedcba) with
//               a blank override that turns every segment off.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_decode
    import sum_bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    // Blank wins over the digit value
    assign o_seg = i_blank ? SEG_BLANK : seg_of_digit(i_digit);

endmodule

`default_nettype wire

// File: rtl/sum_bcd_display.sv
// ============================================================================
// Module      : sum_bcd_display
// Description : Sequential binary-to-BCD converter (shift-and-add-3) with a
//               start/busy/done handshake and an active-low multi-digit
//               7-segment driver with optional leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sum_bcd_display
    import sum_bcd_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DIGITS   = DEFAULT_DIGITS,
    parameter int BLANK_LZ = 1
)(
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iSTART,
    input  logic [WIDTH-1:0]      iBIN,
    output logic                  oBUSY,
    output logic                  oDONE,
    output logic [4*DIGITS-1:0]   oBCD,
    output logic [7*DIGITS-1:0]   oSEG
);

    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_CNT_W = $clog2(WIDTH + 1);

    state_t               r_state;
    logic [WIDTH-1:0]     r_shift;
    logic [c_BCD_W-1:0]   r_scratch;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_busy;
    logic                 r_done;
    logic [c_BCD_W-1:0]   r_bcd;
    logic                 r_valid;

    logic [c_BCD_W-1:0]         w_adj;
    logic [c_BCD_W+WIDTH-1:0]   w_next;
    logic [DIGITS-1:0]          w_blank;

    // Add-3 correction on every scratch digit that is 5 or more; a 4-bit
    // result is enough since 9+3 = 12
    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        assign w_adj[4*k +: 4] = (r_scratch[4*k +: 4] >= 4'd5) ?
                                 (r_scratch[4*k +: 4] + 4'd3) :
                                  r_scratch[4*k +: 4];
    end

    // Joint left shift of {scratch, binary}; the scratch MSB falls off,
    // which is always zero for a legal DIGITS/WIDTH pairing
    assign w_next = {w_adj, r_shift} << 1;

    // Conversion sequencer: capture, WIDTH shift steps, then publish
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_scratch <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
            r_valid   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (iSTART) begin
                        r_shift   <= iBIN;
                        r_scratch <= '0;
                        r_count   <= c_CNT_W'(WIDTH);
                        r_busy    <= 1'b1;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_scratch <= w_next[c_BCD_W+WIDTH-1:WIDTH];
                    r_shift   <= w_next[WIDTH-1:0];
                    r_count   <= r_count - c_CNT_W'(1);
                    if (r_count == c_CNT_W'(1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_bcd   <= r_scratch;
                    r_valid <= 1'b1;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Per-digit blanking: everything dark until a result exists; upper digits
    // also go dark when they and all digits above them are zero
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        if ((BLANK_LZ != 0) && (k > 0)) begin : g_lz
            assign w_blank[k] = ~r_valid | ~(|r_bcd[c_BCD_W-1:4*k]);
        end else begin : g_nolz
            assign w_blank[k] = ~r_valid;
        end

        seg7_decode u_seg7_decode (
            .i_digit (r_bcd[4*k +: 4]),
            .i_blank (w_blank[k]),
            .o_seg   (oSEG[7*k +: 7])
        );
    end

    assign oBUSY = r_busy;
    assign oDONE = r_done;
    assign oBCD  = r_bcd;

endmodule

`default_nettype wire

// File: tb/tb_sum_bcd_display.sv
// ============================================================================
// Module      : tb_sum_bcd_display
// Description : Self-checking bench for sum_bcd_display. Expected BCD values
//               are queued at start time and popped when oDONE fires.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sum_bcd_display;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iSTART;
    logic [8:0]  iBIN;
    logic        oBUSY,    oDONE;
    logic [11:0] oBCD;
    logic [20:0] oSEG;
    logic        oBUSY_nb, oDONE_nb;
    logic [11:0] oBCD_nb;
    logic [20:0] oSEG_nb;

    int          n_vec = 0;
    int          n_err = 0;
    logic [11:0] exp_q[$];

    sum_bcd_display #(.WIDTH(9), .DIGITS(3), .BLANK_LZ(1)) dut (
        .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iBIN(iBIN),
        .oBUSY(oBUSY), .oDONE(oDONE), .oBCD(oBCD), .oSEG(oSEG)
    );

    sum_bcd_display #(.WIDTH(9), .DIGITS(3), .BLANK_LZ(0)) dut_nb (
        .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iBIN(iBIN),
        .oBUSY(oBUSY_nb), .oDONE(oDONE_nb), .oBCD(oBCD_nb), .oSEG(oSEG_nb)
    );

    always #5 iCLK = ~iCLK;

    task automatic tick;
        @(posedge iCLK);
        #1;
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;  default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [20:0] ref_disp(input logic [11:0] b, input bit valid, input bit blz);
        logic [20:0] r;
        logic [3:0]  d;
        bit          lead;
        r    = '1;
        lead = 1'b1;
        for (int k = 2; k >= 0; k--) begin
            d = b[4*k +: 4];
            if (d != 4'd0) lead = 1'b0;
            if (!valid)                    r[7*k +: 7] = 7'h7F;
            else if (blz && lead && k > 0) r[7*k +: 7] = 7'h7F;
            else                           r[7*k +: 7] = ref_seg(d);
        end
        return r;
    endfunction

    // Waits (bounded) for oDONE; returns whether it came and after how many ticks
    task automatic wait_done(output bit seen, output int cyc);
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            cyc++;
            if (oDONE === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        iRST = 1'b1; iSTART = 1'b0; iBIN = '0;
        repeat (3) tick();
        n_vec++; if (oBUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", oBUSY); end
        n_vec++; if (oDONE !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", oDONE); end
        n_vec++; if (oBCD !== 12'h000) begin n_err++; $display("FAIL reset_bcd got=%h want=000", oBCD); end
        n_vec++; if (oSEG !== 21'h1FFFFF) begin n_err++; $display("FAIL reset_seg got=%h want=1fffff", oSEG); end
        iRST = 1'b0;
        repeat (2) tick();
        n_vec++; if (oSEG !== 21'h1FFFFF) begin n_err++; $display("FAIL idle_no_start_seg got=%h want=1fffff", oSEG); end
    endtask

    task automatic test_max_latency;
        bit          seen;
        int          cyc;
        logic [11:0] e;
        iBIN = 9'd511; iSTART = 1'b1;
        exp_q.push_back(to_bcd(511));
        tick();
        iSTART = 1'b0;
        n_vec++; if (oBUSY !== 1'b1) begin n_err++; $display("FAIL busy_after_start got=%b want=1", oBUSY); end
        wait_done(seen, cyc);
        n_vec++;
        if (!seen) begin
            n_err++; $display("FAIL max_done_timeout got=none want=oDONE");
        end else begin
            if (cyc + 1 !== 11) begin n_err++; $display("FAIL max_latency got=%0d want=11", cyc + 1); end
            e = exp_q.pop_front();
            n_vec++; if (oBCD !== e) begin n_err++; $display("FAIL max_bcd got=%h want=%h", oBCD, e); end
            n_vec++; if (oSEG !== ref_disp(e, 1'b1, 1'b1)) begin n_err++; $display("FAIL max_seg got=%h want=%h", oSEG, ref_disp(e, 1'b1, 1'b1)); end
            n_vec++; if (oBUSY !== 1'b0) begin n_err++; $display("FAIL busy_at_done got=%b want=0", oBUSY); end
        end
        tick();
        n_vec++; if (oDONE !== 1'b0) begin n_err++; $display("FAIL done_one_cycle got=%b want=0", oDONE); end
        n_vec++; if (oBCD !== 12'h511) begin n_err++; $display("FAIL bcd_hold got=%h want=511", oBCD); end
    endtask

    task automatic test_zero_blank;
        bit          seen;
        int          cyc;
        logic [11:0] e;
        iBIN = 9'd0; iSTART = 1'b1;
        exp_q.push_back(to_bcd(0));
        tick();
        iSTART = 1'b0;
        wait_done(seen, cyc);
        n_vec++;
        if (!seen) begin
            n_err++; $display("FAIL zero_done_timeout got=none want=oDONE");
        end else begin
            e = exp_q.pop_front();
            if (oBCD !== e) begin n_err++; $display("FAIL zero_bcd got=%h want=%h", oBCD, e); end
            n_vec++; if (oSEG !== ref_disp(e, 1'b1, 1'b1)) begin n_err++; $display("FAIL zero_seg_lz got=%h want=%h", oSEG, ref_disp(e, 1'b1, 1'b1)); end
            n_vec++; if (oSEG_nb !== ref_disp(e, 1'b1, 1'b0)) begin n_err++; $display("FAIL zero_seg_nolz got=%h want=%h", oSEG_nb, ref_disp(e, 1'b1, 1'b0)); end
        end
        tick();
    endtask

    task automatic test_start_ignored;
        int          n_done;
        logic [11:0] e;
        n_done = 0;
        iBIN = 9'd255 + 9'd255; iSTART = 1'b1;
        exp_q.push_back(to_bcd(510));
        tick();
        iSTART = 1'b0; iBIN = 9'd7;
        repeat (2) tick();
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (oDONE === 1'b1) begin
                n_done++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL ignore_extra_result got=%h want=none", oBCD);
                end else begin
                    e = exp_q.pop_front();
                    if (oBCD !== e) begin n_err++; $display("FAIL ignore_bcd got=%h want=%h", oBCD, e); end
                end
            end
        end
        n_vec++; if (n_done !== 1) begin n_err++; $display("FAIL ignore_done_count got=%0d want=1", n_done); end
        n_vec++; if (oBUSY !== 1'b0) begin n_err++; $display("FAIL ignore_idle_busy got=%b want=0", oBUSY); end
    endtask

    task automatic test_reset_abort;
        bit          seen;
        int          cyc;
        logic [11:0] e;
        iBIN = 9'd42; iSTART = 1'b1;
        exp_q.push_back(to_bcd(42));
        tick();
        iSTART = 1'b0;
        wait_done(seen, cyc);
        n_vec++;
        if (!seen) begin
            n_err++; $display("FAIL prior_done_timeout got=none want=oDONE");
        end else begin
            e = exp_q.pop_front();
            if (oBCD !== e) begin n_err++; $display("FAIL prior_bcd got=%h want=%h", oBCD, e); end
        end
        tick();
        iBIN = 9'd300; iSTART = 1'b1;
        exp_q.push_back(to_bcd(300));
        tick();
        iSTART = 1'b0;
        repeat (4) tick();
        #2 iRST = 1'b1;
        #1;
        exp_q.delete();
        n_vec++; if (oBUSY !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b want=0", oBUSY); end
        n_vec++; if (oBCD !== 12'h000) begin n_err++; $display("FAIL abort_bcd got=%h want=000", oBCD); end
        n_vec++; if (oSEG !== 21'h1FFFFF) begin n_err++; $display("FAIL abort_seg got=%h want=1fffff", oSEG); end
        n_vec++; if (oDONE !== 1'b0) begin n_err++; $display("FAIL abort_done got=%b want=0", oDONE); end
        tick();
        iRST = 1'b0;
        tick();
        n_vec++; if (oSEG_nb !== 21'h1FFFFF) begin n_err++; $display("FAIL abort_seg_nolz got=%h want=1fffff", oSEG_nb); end
        iBIN = 9'd300; iSTART = 1'b1;
        exp_q.push_back(to_bcd(300));
        tick();
        iSTART = 1'b0;
        wait_done(seen, cyc);
        n_vec++;
        if (!seen) begin
            n_err++; $display("FAIL rerun_done_timeout got=none want=oDONE");
        end else begin
            e = exp_q.pop_front();
            if (oBCD !== e) begin n_err++; $display("FAIL rerun_bcd got=%h want=%h", oBCD, e); end
            n_vec++; if (oSEG !== ref_disp(e, 1'b1, 1'b1)) begin n_err++; $display("FAIL rerun_seg got=%h want=%h", oSEG, ref_disp(e, 1'b1, 1'b1)); end
        end
        tick();
    endtask

    task automatic test_back_to_back;
        bit          seen;
        int          cyc;
        logic [11:0] e;
        iBIN = 9'd99; iSTART = 1'b1;
        for (int r = 0; r < 3; r++) begin
            exp_q.push_back(to_bcd(99));
            wait_done(seen, cyc);
            n_vec++;
            if (!seen) begin
                n_err++; $display("FAIL b2b_done_timeout round=%0d got=none want=oDONE", r);
            end else begin
                if (cyc !== 11) begin n_err++; $display("FAIL b2b_period round=%0d got=%0d want=11", r, cyc); end
                e = exp_q.pop_front();
                n_vec++; if (oBCD !== e) begin n_err++; $display("FAIL b2b_bcd round=%0d got=%h want=%h", r, oBCD, e); end
                n_vec++; if (oSEG !== ref_disp(e, 1'b1, 1'b1)) begin n_err++; $display("FAIL b2b_seg round=%0d got=%h want=%h", r, oSEG, ref_disp(e, 1'b1, 1'b1)); end
            end
        end
        iSTART = 1'b0;
        repeat (3) tick();
        n_vec++; if (oBUSY !== 1'b0) begin n_err++; $display("FAIL b2b_stop_busy got=%b want=0", oBUSY); end
    endtask

    initial begin
        test_reset();
        test_max_latency();
        test_zero_blank();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
